// File: rtl/quadra_pipe.sv
// Pipelined piecewise-quadratic evaluator: y = sat(a + b*x2 + c*x2^2) with per-segment coefficients.
// Four register stages with a global stall; the coefficient table is runtime-writable.
module quadra_pipe #(
  parameter int unsigned XW   = 16,
  parameter int unsigned SEGW = 7,
  parameter int unsigned AW   = 24,
  parameter int unsigned BW   = 18,
  parameter int unsigned CW   = 18,
  parameter int unsigned YW   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XW-1:0]          x,
  input  logic                   x_dv,
  output logic                   x_rdy,
  output logic signed [YW-1:0]   y,
  output logic                   y_dv,
  input  logic                   y_rdy,
  output logic                   y_sat,
  input  logic                   cfg_we,
  input  logic [SEGW-1:0]        cfg_addr,
  input  logic signed [AW-1:0]   cfg_a,
  input  logic signed [BW-1:0]   cfg_b,
  input  logic signed [CW-1:0]   cfg_c
);

  localparam int unsigned X2W   = XW - SEGW;
  localparam int unsigned Depth = 1 << SEGW;
  localparam int unsigned MW0   = (AW > BW) ? AW : BW;
  localparam int unsigned MW    = (MW0 > CW) ? MW0 : CW;
  localparam int unsigned SW    = MW + 2;

  logic signed [AW-1:0] tab_a [Depth];
  logic signed [BW-1:0] tab_b [Depth];
  logic signed [CW-1:0] tab_c [Depth];

  logic [SEGW-1:0] x1;
  logic [X2W-1:0]  x2;
  logic            stall;

  logic                 v1, v2, v3;
  logic [X2W-1:0]       s1_x2;
  logic signed [AW-1:0] s1_a, s2_a, s3_a;
  logic signed [BW-1:0] s1_b, s2_pb, s3_pb;
  logic signed [CW-1:0] s1_c, s2_c, s3_pc;
  logic [X2W-1:0]       s2_sq;

  assign x1    = x[XW-1:X2W];
  assign x2    = x[X2W-1:0];
  assign stall = y_dv & ~y_rdy;
  assign x_rdy = ~stall;

  // Table write is independent of stall; reset blocks it.
  always_ff @(posedge clk) begin
    if (cfg_we && !rst) begin
      tab_a[cfg_addr] <= cfg_a;
      tab_b[cfg_addr] <= cfg_b;
      tab_c[cfg_addr] <= cfg_c;
    end
  end

  // Stage 2 arithmetic. Slicing the full product at X2W is an arithmetic shift (floor);
  // the results provably fit the coefficient widths since x2, sq < 1.0.
  logic [2*X2W-1:0]         sq_full;
  logic signed [BW+X2W:0]   pb_full;
  logic [X2W-1:0]           sq_n;
  logic signed [BW-1:0]     pb_n;

  assign sq_full = s1_x2 * s1_x2;
  assign pb_full = s1_b * $signed({1'b0, s1_x2});
  assign sq_n    = sq_full[X2W +: X2W];
  assign pb_n    = $signed(pb_full[X2W +: BW]);

  // Stage 3 arithmetic.
  logic signed [CW+X2W:0] pc_full;
  logic signed [CW-1:0]   pc_n;

  assign pc_full = s2_c * $signed({1'b0, s2_sq});
  assign pc_n    = $signed(pc_full[X2W +: CW]);

  // Stage 4: full-precision sum and saturation to YW.
  logic signed [SW-1:0] a_ext, pb_ext, pc_ext, sum_n;
  logic                 pos_ovf, neg_ovf, sat_n;
  logic signed [YW-1:0] y_n;

  assign a_ext  = {{(SW-AW){s3_a[AW-1]}}, s3_a};
  assign pb_ext = {{(SW-BW){s3_pb[BW-1]}}, s3_pb};
  assign pc_ext = {{(SW-CW){s3_pc[CW-1]}}, s3_pc};
  assign sum_n  = a_ext + pb_ext + pc_ext;

  // Bits above the YW sign bit must all match the sign, otherwise the sum is out of range.
  assign pos_ovf = ~sum_n[SW-1] & (|sum_n[SW-2:YW-1]);
  assign neg_ovf = sum_n[SW-1] & ~(&sum_n[SW-2:YW-1]);
  assign sat_n   = pos_ovf | neg_ovf;

  always_comb begin
    y_n = sum_n[YW-1:0];
    if (pos_ovf) begin
      y_n = {1'b0, {(YW-1){1'b1}}};
    end else if (neg_ovf) begin
      y_n = {1'b1, {(YW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      y_dv  <= 1'b0;
      y     <= '0;
      y_sat <= 1'b0;
    end else if (!stall) begin
      v1    <= x_dv;
      s1_x2 <= x2;
      s1_a  <= tab_a[x1];
      s1_b  <= tab_b[x1];
      s1_c  <= tab_c[x1];

      v2    <= v1;
      s2_a  <= s1_a;
      s2_pb <= pb_n;
      s2_sq <= sq_n;
      s2_c  <= s1_c;

      v3    <= v2;
      s3_a  <= s2_a;
      s3_pb <= s2_pb;
      s3_pc <= pc_n;

      y_dv  <= v3;
      if (v3) begin
        y     <= y_n;
        y_sat <= sat_n;
      end
    end
  end

endmodule

// File: tb/tb_quadra_pipe.sv
// Directed self-checking bench for quadra_pipe: latency, arithmetic, saturation,
// backpressure, same-cycle table write ordering and mid-stream reset.
module tb_quadra_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        x;
  logic               x_dv;
  logic               x_rdy;
  logic signed [19:0] y;
  logic               y_dv;
  logic               y_rdy;
  logic               y_sat;
  logic               cfg_we;
  logic [6:0]         cfg_addr;
  logic signed [23:0] cfg_a;
  logic signed [17:0] cfg_b;
  logic signed [17:0] cfg_c;

  int n_cmp = 0;
  int n_bad = 0;

  int q_y[$];
  int q_sat[$];
  bit hold_prev = 1'b0;
  int hold_y    = 0;
  int hold_sat  = 0;

  always #5 clk = ~clk;

  quadra_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .x_dv     (x_dv),
    .x_rdy    (x_rdy),
    .y        (y),
    .y_dv     (y_dv),
    .y_rdy    (y_rdy),
    .y_sat    (y_sat),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_a    (cfg_a),
    .cfg_b    (cfg_b),
    .cfg_c    (cfg_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: logs every transfer and checks output stability across stalled cycles.
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_dv", int'(y_dv), 1);
      check("hold_y", int'(y), hold_y);
      check("hold_sat", int'(y_sat), hold_sat);
    end
    if (y_dv && y_rdy) begin
      q_y.push_back(int'(y));
      q_sat.push_back(int'(y_sat));
    end
    hold_prev = y_dv & ~y_rdy;
    hold_y    = int'(y);
    hold_sat  = int'(y_sat);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int a, input int b, input int c);
    cfg_we   = 1'b1;
    cfg_addr = addr[6:0];
    cfg_a    = a[23:0];
    cfg_b    = b[17:0];
    cfg_c    = c[17:0];
    step();
    cfg_we   = 1'b0;
  endtask

  // Send one sample into an idle pipe; latency counts rising edges, accepting edge included.
  task automatic send_one(input string tag, input int xv, input int exp_y, input int exp_sat,
                          input bit chk_lat);
    int lat;
    x    = xv[15:0];
    x_dv = 1'b1;
    step();
    x_dv = 1'b0;
    lat  = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (y_dv) break;
      step();
      lat++;
    end
    if (chk_lat) check({tag, "_lat"}, lat, 4);
    check({tag, "_y"}, int'(y), exp_y);
    check({tag, "_sat"}, int'(y_sat), exp_sat);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic expect_queue(input string tag, input int n, input int base, input int incr);
    check({tag, "_count"}, q_y.size(), n);
    for (int i = 0; i < n && i < q_y.size(); i++) begin
      check($sformatf("%s_out%0d", tag, i), q_y[i], base + i * incr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; x = '0; x_dv = 1'b0; y_rdy = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_y", int'(y), 0);
    check("rst_dv", int'(y_dv), 0);
    check("rst_sat", int'(y_sat), 0);
    check("rst_rdy", int'(x_rdy), 1);
    step();

    // 1: linear term, 1000 + 512*256/512
    cfg_write(5, 1000, 512, 0);
    send_one("t1", (5 << 9) | 256, 1256, 0, 1'b1);

    // 2: quadratic term, sq = 256*256>>9 = 128, pc = 1024*128>>9 = 256
    cfg_write(0, 0, 0, 1024);
    send_one("t2a", 256, 256, 0, 1'b0);
    send_one("t2b", 0, 0, 0, 1'b0);

    // 3: saturation in both directions on the last segment
    cfg_write(127, 8388607, 0, 0);
    send_one("t3pos", 16'hFFFF, 524287, 1, 1'b0);
    cfg_write(127, -8388608, 0, 0);
    send_one("t3neg", 16'hFFFF, -524288, 1, 1'b0);
    drain();

    // 4: back-to-back stream with a 3-cycle downstream stall
    q_y.delete(); q_sat.delete();
    fork
      begin
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < 6 && guard < 40) begin
          x    = 16'((5 << 9) | i);
          x_dv = 1'b1;
          @(negedge clk);
          acc = x_rdy;
          step();
          if (acc) i++;
          guard++;
        end
        x_dv = 1'b0;
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!y_dv && w < 20) begin
          @(negedge clk);
          w++;
        end
        step();
        y_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t4_xrdy_stall", int'(x_rdy), 0);
          step();
        end
        y_rdy = 1'b1;
      end
    join
    drain();
    expect_queue("t4", 6, 1000, 1);

    // 5: write to seg5 in the same cycle a seg5 sample is accepted
    q_y.delete(); q_sat.delete();
    cfg_we = 1'b1; cfg_addr = 7'd5; cfg_a = 24'sd2000; cfg_b = 18'sd512; cfg_c = '0;
    x = 16'(5 << 9); x_dv = 1'b1;
    step();
    cfg_we = 1'b0;
    step();
    x_dv = 1'b0;
    drain();
    expect_queue("t5", 2, 1000, 1000);

    // 6: reset flushes in-flight samples
    q_y.delete(); q_sat.delete();
    x_dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 16'((5 << 9) | i);
      step();
    end
    x_dv = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    @(negedge clk);
    check("t6_dv", int'(y_dv), 0);
    check("t6_xrdy", int'(x_rdy), 1);
    check("t6_y", int'(y), 0);
    drain();
    check("t6_count", q_y.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
